ex_result_sel_mdu: RTL and testbench
====================================

Name: ex_result_sel_mdu

Overview:
Execute-stage result selector for the 5-stage MIPS pipeline. It adds an integrated multi-cycle multiply/divide unit with architectural HI/LO registers.
- Selects the E-stage forwarded/registered result from: ALU output, immediate (lui path), link address (pc+LINK_OFFSET), HI or LO.
- Exposes busy/stall status so the hazard unit can stall md-class instructions while an operation is in flight.

Parameters:
WIDTH, 32, datapath width of all operands, HI, LO and out.
MULT_CYCLES, 5, busy duration for mult/multu (>=1).
DIV_CYCLES, 10, busy duration for div/divu (>=1).
LINK_OFFSET, 8, added to pc for the link result.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
alu_out  in  WIDTH  ALU result.
imm  in  WIDTH  extended immediate (already shifted for lui).
pc  in  WIDTH  E-stage instruction pc.
res_sel  in  3  result source: 0 ALU, 1 IMM, 2 LINK, 3 HI, 4 LO; 5-7 treated as ALU.
md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none.
md_start  in  1  qualifies md_op this cycle; one-cycle pulse per instruction.
flush  in  1  E-stage squash (exception/interrupt); suppresses md_start in the same cycle.
rs_val  in  WIDTH  operand A (dividend / mthi/mtlo source).
rt_val  in  WIDTH  operand B (divisor).
out  out  WIDTH  selected result, combinational.
md_busy  out  1  operation in flight.
md_stall  out  1  md_busy OR (md_start AND op in 1..4 AND NOT flush); for the hazard unit.

Behaviour:
- Reset: HI=0, LO=0, counter=0, md_busy=0, pending results cleared.
- Result selection, combinational:
  - out = alu_out / imm / pc+LINK_OFFSET (mod 2^WIDTH) / HI / LO, chosen by res_sel.
  - HI/LO reads return the architectural (committed) values; old values are returned while md_busy.
- Accepted start: md_start=1 AND flush=0 AND md_busy=0 AND md_op!=none.
- mult/multu/div/divu:
  - Product/quotient/remainder are computed from rs_val/rt_val on the accept edge and held in pending registers.
  - counter loads MULT_CYCLES or DIV_CYCLES; md_busy=1 from the next cycle.
  - counter decrements each cycle while >0. On the edge where it goes 1->0, pending values are written to HI/LO and md_busy falls.
  - With start at edge t0 and N cycles, md_busy=1 for cycles t0+1..t0+N. New HI/LO are visible from cycle t0+N+1.
- mthi/mtlo: HI/LO <= rs_val on the accept edge. No busy.
- mult/multu: {HI,LO} = signed/unsigned 2*WIDTH product.
- div/divu: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Signed MIN/-1: LO=MIN, HI=0.
  - Divisor 0: HI/LO remain unchanged at completion, but busy timing is still applied.
- md_start while md_busy: ignored, with no state change. The hazard unit must hold the instruction via md_stall.
- flush in a cycle with md_start: start suppressed. An in-flight operation is never cancelled by flush.
- reset asserted mid-operation: aborts immediately; all state goes to reset values on that edge.
- md_op=none with md_start: no effect.

Decomposition:
- Shared package mips_pkg:
  - res_sel encodings (RES_ALU, RES_IMM, RES_LINK, RES_HI, RES_LO).
  - md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
- Sub-module md_unit: HI/LO, counter, pending registers, arithmetic, md_busy.
- Top level: output mux and md_stall.

Test Plan:
- Reset then res_sel=LINK, pc=0x00003000 -> out=0x00003008. res_sel=HI -> 0. res_sel=IMM, imm=0x12340000 -> 0x12340000.
- mult, rs=0xFFFFFFFF, rt=2, start at t0:
  - md_busy high for exactly 5 cycles.
  - HI read during busy returns the old value 0.
  - From t0+6: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Same operands with multu: HI=0x00000001, LO=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2:
  - 10 busy cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu rs=7, rt=2 gives LO=3, HI=1.
- Boundary division:
  - div rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - div by 0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> HI/LO unchanged after 10 busy cycles.
- md_start(mult) during busy of a div -> ignored; only the div result lands.
- Start/flush/reset interactions:
  - md_start with flush=1 -> md_busy stays 0, md_stall=0, HI/LO unchanged.
  - mtlo with rs=0x5A -> LO=0x5A on the next cycle, md_busy stays 0.
  - reset at busy cycle 3 -> md_busy=0, HI=LO=0 on the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: result-source select and
// multiply/divide operation codes.
package mips_pkg;

    typedef enum logic [2:0] {
        RES_ALU  = 3'd0,
        RES_IMM  = 3'd1,
        RES_LINK = 3'd2,
        RES_HI   = 3'd3,
        RES_LO   = 3'd4
    } res_sel_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Multi-cycle ops (mult/multu/div/divu) are the ones that occupy the unit.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_result_sel_mdu_if.sv
// E-stage operand/result bundle between the pipeline (master) and the
// result selector with its multiply/divide unit (slave).
interface ex_result_sel_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [2:0]       res_sel;
    logic [2:0]       md_op;
    logic             md_start;
    logic             flush;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] out;
    logic             md_busy;
    logic             md_stall;

    modport master (
        output alu_out, imm, pc, res_sel, md_op, md_start, flush, rs_val, rt_val,
        input  out, md_busy, md_stall
    );

    modport slave (
        input  alu_out, imm, pc, res_sel, md_op, md_start, flush, rs_val, rt_val,
        output out, md_busy, md_stall
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are captured at issue and committed when the busy countdown expires.
module md_unit
    import mips_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0]    MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0]    DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);

    logic [CW-1:0]      cnt_r;
    logic               busy_r;
    logic [WIDTH-1:0]   hi_r, lo_r, pend_hi_r, pend_lo_r;
    logic               pend_wr_r;

    logic               accept_s;
    logic [2*WIDTH-1:0] sprod_s, uprod_s;
    logic               a_neg_s, b_neg_s, div_zero_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s;
    logic [WIDTH-1:0]   sq_s, sr_s, ub_safe_s, uq_s, ur_s;

    // Issue qualification: op 7 and none never start anything.
    always_comb begin
        accept_s = 1'b0;
        if (md_start && !flush && !busy_r) begin
            case (md_op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: accept_s = 1'b1;
                default: accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Arithmetic on the issuing operands. Signed divide works on magnitudes so
    // MIN/-1 yields MIN with zero remainder without overflow.
    always_comb begin
        sprod_s    = {{WIDTH{rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
        uprod_s    = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};
        div_zero_s = (rt_val == ZERO);
        a_neg_s    = rs_val[WIDTH-1];
        b_neg_s    = rt_val[WIDTH-1];
        a_mag_s    = a_neg_s ? (~rs_val + ONE) : rs_val;
        b_mag_s    = b_neg_s ? (~rt_val + ONE) : rt_val;
        b_safe_s   = div_zero_s ? ONE : b_mag_s;
        q_mag_s    = a_mag_s / b_safe_s;
        r_mag_s    = a_mag_s % b_safe_s;
        sq_s       = (a_neg_s ^ b_neg_s) ? (~q_mag_s + ONE) : q_mag_s;
        sr_s       = a_neg_s ? (~r_mag_s + ONE) : r_mag_s;
        ub_safe_s  = div_zero_s ? ONE : rt_val;
        uq_s       = rs_val / ub_safe_s;
        ur_s       = rs_val % ub_safe_s;
    end

    // HI/LO, pending result and busy countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r      <= ZERO;
            lo_r      <= ZERO;
            pend_hi_r <= ZERO;
            pend_lo_r <= ZERO;
            pend_wr_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
        end else if (accept_s) begin
            case (md_op)
                MD_MULT: begin
                    pend_hi_r <= sprod_s[2*WIDTH-1:WIDTH];
                    pend_lo_r <= sprod_s[WIDTH-1:0];
                    pend_wr_r <= 1'b1;
                    cnt_r     <= MULT_CNT;
                    busy_r    <= 1'b1;
                end
                MD_MULTU: begin
                    pend_hi_r <= uprod_s[2*WIDTH-1:WIDTH];
                    pend_lo_r <= uprod_s[WIDTH-1:0];
                    pend_wr_r <= 1'b1;
                    cnt_r     <= MULT_CNT;
                    busy_r    <= 1'b1;
                end
                MD_DIV: begin
                    pend_hi_r <= sr_s;
                    pend_lo_r <= sq_s;
                    pend_wr_r <= !div_zero_s;
                    cnt_r     <= DIV_CNT;
                    busy_r    <= 1'b1;
                end
                MD_DIVU: begin
                    pend_hi_r <= ur_s;
                    pend_lo_r <= uq_s;
                    pend_wr_r <= !div_zero_s;
                    cnt_r     <= DIV_CNT;
                    busy_r    <= 1'b1;
                end
                MD_MTHI: hi_r <= rs_val;
                MD_MTLO: lo_r <= rs_val;
                default: begin
                end
            endcase
        end else if (busy_r) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                busy_r <= 1'b0;
                if (pend_wr_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end
        end
    end

    assign hi      = hi_r;
    assign lo      = lo_r;
    assign md_busy = busy_r;

endmodule

// File: rtl/ex_result_sel_mdu.sv
// Execute-stage result selector: muxes ALU/imm/link/HI/LO onto the forwarded
// result and reports multiply/divide occupancy to the hazard unit.
module ex_result_sel_mdu
    import mips_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int LINK_OFFSET = 8
) (
    input  logic                clk,
    input  logic                reset,
    ex_result_sel_mdu_if.slave  bus
);
    localparam logic [WIDTH-1:0] LINK_ADD = WIDTH'(LINK_OFFSET);

    logic [WIDTH-1:0] hi_s, lo_s, link_s, out_s;
    logic             busy_s;

    md_unit #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_unit (
        .clk      (clk),
        .reset    (reset),
        .md_op    (bus.md_op),
        .md_start (bus.md_start),
        .flush    (bus.flush),
        .rs_val   (bus.rs_val),
        .rt_val   (bus.rt_val),
        .hi       (hi_s),
        .lo       (lo_s),
        .md_busy  (busy_s)
    );

    // Result source mux; unused select codes fall back to the ALU.
    always_comb begin
        link_s = bus.pc + LINK_ADD;
        out_s  = bus.alu_out;
        case (bus.res_sel)
            RES_ALU:  out_s = bus.alu_out;
            RES_IMM:  out_s = bus.imm;
            RES_LINK: out_s = link_s;
            RES_HI:   out_s = hi_s;
            RES_LO:   out_s = lo_s;
            default:  out_s = bus.alu_out;
        endcase
    end

    assign bus.out      = out_s;
    assign bus.md_busy  = busy_s;
    assign bus.md_stall = busy_s | (bus.md_start & md_is_long(bus.md_op) & ~bus.flush);

endmodule

// File: tb/tb_ex_result_sel_mdu.sv
// Randomized scoreboard bench for ex_result_sel_mdu against a timestamp-based
// reference model of HI/LO and multiply/divide occupancy.
module tb_ex_result_sel_mdu;
    import mips_pkg::*;

    localparam int NMULT = 5;
    localparam int NDIV  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_result_sel_mdu_if #(.WIDTH(32)) bus();

    ex_result_sel_mdu #(
        .WIDTH(32), .MULT_CYCLES(NMULT), .DIV_CYCLES(NDIV), .LINK_OFFSET(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        busy;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pwr = 1'b0, m_busy = 1'b0;
    int          m_edge = 0, m_done = 0;

    // Stimulus for the current cycle
    logic [31:0] st_alu = 32'd0, st_imm = 32'd0, st_pc = 32'd0, st_a = 32'd0, st_b = 32'd0;
    logic [2:0]  st_res = 3'd0, st_op = 3'd0;
    bit          st_start = 1'b0, st_flush = 1'b0, st_rst = 1'b0;

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
        end
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk(mon_e.name, "out", bus.out, mon_e.out);
            chk(mon_e.name, "md_busy", {31'd0, bus.md_busy}, {31'd0, mon_e.busy});
            chk(mon_e.name, "md_stall", {31'd0, bus.md_stall}, {31'd0, mon_e.stall});
        end
    end

    task automatic model_edge();
        logic [63:0] p;
        int sa, sb;
        m_edge++;
        if (st_rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_pwr = 1'b0;
        end else if (m_busy) begin
            if (m_edge == m_done) begin
                m_busy = 1'b0;
                if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (st_start && !st_flush && st_op >= 3'd1 && st_op <= 3'd6) begin
            sa = $signed(st_a);
            sb = $signed(st_b);
            m_pwr = 1'b1;
            case (st_op)
                3'd1: begin p = 64'(longint'(sa) * longint'(sb)); {m_phi, m_plo} = p; end
                3'd2: begin p = {32'd0, st_a} * {32'd0, st_b}; {m_phi, m_plo} = p; end
                3'd3: begin
                    if (sb == 0) m_pwr = 1'b0;
                    else if (st_a == 32'h8000_0000 && sb == -1) begin
                        m_plo = 32'h8000_0000; m_phi = 32'd0;
                    end else begin
                        m_plo = 32'(sa / sb); m_phi = 32'(sa % sb);
                    end
                end
                3'd4: begin
                    if (st_b == 32'd0) m_pwr = 1'b0;
                    else begin m_plo = st_a / st_b; m_phi = st_a % st_b; end
                end
                3'd5: m_hi = st_a;
                default: m_lo = st_a;
            endcase
            if (st_op <= 3'd4) begin
                m_busy = 1'b1;
                m_done = m_edge + ((st_op <= 3'd2) ? NMULT : NDIV);
            end
        end
    endtask

    // Drive one cycle, queue its expected outputs, then advance the model.
    task automatic step(input string nm);
        exp_t e;
        bus.alu_out = st_alu; bus.imm = st_imm; bus.pc = st_pc;
        bus.res_sel = st_res; bus.md_op = st_op; bus.md_start = st_start;
        bus.flush = st_flush; bus.rs_val = st_a; bus.rt_val = st_b;
        reset = st_rst;
        case (st_res)
            3'd1:    e.out = st_imm;
            3'd2:    e.out = st_pc + 32'd8;
            3'd3:    e.out = m_hi;
            3'd4:    e.out = m_lo;
            default: e.out = st_alu;
        endcase
        e.name  = nm;
        e.busy  = m_busy;
        e.stall = m_busy || (st_start && st_op >= 3'd1 && st_op <= 3'd4 && !st_flush);
        sb_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [2:0] rs, input string nm);
        st_start = 1'b0; st_op = 3'd0; st_res = rs;
        for (int i = 0; i < n; i++) step(nm);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rs, input string nm);
        st_op = op; st_a = a; st_b = b; st_res = rs; st_start = 1'b1;
        step(nm);
        st_start = 1'b0; st_op = 3'd0;
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        bus.alu_out = 32'd0; bus.imm = 32'd0; bus.pc = 32'd0; bus.res_sel = 3'd0;
        bus.md_op = 3'd0; bus.md_start = 1'b0; bus.flush = 1'b0;
        bus.rs_val = 32'd0; bus.rt_val = 32'd0;
        repeat (3) @(posedge clk);
        #1;

        st_pc = 32'h0000_3000; st_res = RES_LINK; step("link");
        st_res = RES_HI; step("hi_reset");
        st_imm = 32'h1234_0000; st_res = RES_IMM; step("imm");

        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, RES_HI, "mult_issue");
        idle(NMULT - 1, RES_HI, "mult_busy_hi");
        idle(2, RES_HI, "mult_hi"); idle(1, RES_LO, "mult_lo");
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, RES_LO, "multu_issue");
        idle(NMULT + 1, RES_HI, "multu_hi"); idle(1, RES_LO, "multu_lo");

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, RES_LO, "div_issue");
        idle(NDIV + 1, RES_LO, "div_lo"); idle(1, RES_HI, "div_hi");
        issue(MD_DIVU, 32'd7, 32'd2, RES_LO, "divu_issue");
        idle(NDIV + 1, RES_LO, "divu_lo"); idle(1, RES_HI, "divu_hi");
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, RES_LO, "divmin_issue");
        idle(NDIV + 1, RES_LO, "divmin_lo"); idle(1, RES_HI, "divmin_hi");

        issue(MD_MTHI, 32'h11, 32'd0, RES_HI, "mthi");
        issue(MD_MTLO, 32'h22, 32'd0, RES_LO, "mtlo");
        issue(MD_DIV, 32'h55, 32'd0, RES_HI, "div0_issue");
        idle(NDIV + 1, RES_HI, "div0_hi"); idle(1, RES_LO, "div0_lo");

        issue(MD_DIV, 32'd100, 32'd7, RES_LO, "divbusy_issue");
        idle(2, RES_LO, "divbusy_wait");
        issue(MD_MULT, 32'd3, 32'd4, RES_LO, "mult_ignored");
        idle(NDIV, RES_LO, "divbusy_lo"); idle(1, RES_HI, "divbusy_hi");

        st_flush = 1'b1;
        issue(MD_MULT, 32'd9, 32'd9, RES_HI, "flush_issue");
        st_flush = 1'b0;
        idle(2, RES_HI, "flush_after");
        issue(MD_MTLO, 32'h5A, 32'd0, RES_LO, "mtlo5a");
        idle(1, RES_LO, "mtlo5a_lo");

        issue(MD_MULT, 32'd1234, 32'd5678, RES_HI, "rst_issue");
        idle(2, RES_HI, "rst_busy");
        st_rst = 1'b1; step("rst_mid"); st_rst = 1'b0;
        idle(1, RES_HI, "rst_hi"); idle(1, RES_LO, "rst_lo");

        for (int i = 0; i < 400; i++) begin
            st_alu   = $urandom; st_imm = $urandom; st_pc = $urandom;
            st_res   = 3'($urandom_range(0, 7));
            st_op    = 3'($urandom_range(0, 7));
            st_start = ($urandom_range(0, 9) < 3);
            st_flush = ($urandom_range(0, 9) == 0);
            st_rst   = ($urandom_range(0, 99) == 0);
            st_a     = pick_opnd();
            st_b     = pick_opnd();
            step("rand");
        end
        st_start = 1'b0; st_flush = 1'b0; st_rst = 1'b0;
        idle(NDIV + 2, RES_HI, "final_hi");
        idle(1, RES_LO, "final_lo");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
